// File: rtl/fetch_q.sv
// Instruction fetch queue: issues sequential fetches under a credit limit, buffers
// responses in a DEPTH-entry FIFO and hands them to decode in order; supports redirect.
module fetch_q #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_imem_req,
    output logic [XLEN-1:0]            o_imem_addr,
    input  logic [31:0]                i_imem_rdata,
    output logic                       hs_fq4dc_val,
    input  logic                       hs_dc4fq_rdy,
    output logic [XLEN-1:0]            o_pc,
    output logic [31:0]                o_in,
    input  logic                       i_redir,
    input  logic [XLEN-1:0]            i_redir_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] inflight_pc_reg;
    logic            inflight_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   head_reg, head_next;
    logic [PW-1:0]   tail_reg, tail_next;

    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [31:0]     in_mem [DEPTH];
    logic [XLEN-1:0] head_pc_reg;
    logic [31:0]     head_in_reg;

    logic            req;
    logic            push;
    logic            pop;
    logic            val;
    logic [CW:0]     credit;
    logic            unused_redir_lsb;

    assign unused_redir_lsb = ^i_redir_pc[1:0];

    // Entries already queued plus the one still on its way from memory; a pop in
    // this cycle is deliberately not credited back.
    assign credit = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign req    = !rst && !i_redir && (credit < (CW+1)'(DEPTH));
    assign push   = !rst && !i_redir && inflight_reg;
    assign val    = !rst && !i_redir && (count_reg != '0);
    assign pop    = val && hs_dc4fq_rdy;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (rst || i_redir) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (pop)
                head_next = head_reg + 1'b1;
            if (push)
                tail_next = tail_reg + 1'b1;
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else if (i_redir) begin
            fetch_pc_reg    <= {i_redir_pc[XLEN-1:2], 2'b00};
            inflight_reg    <= 1'b0;
        end else begin
            inflight_reg <= req;
            if (req) begin
                inflight_pc_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        head_reg  <= head_next;
        tail_reg  <= tail_next;
        count_reg <= count_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg] <= inflight_pc_reg;
            in_mem[tail_reg] <= i_imem_rdata;
        end
    end

    // Registered read addressed by the next head; when the entry being written this
    // edge is the next head, forward the write data so the head register is current.
    always_ff @(posedge clk) begin
        if (push && (tail_reg == head_next)) begin
            head_pc_reg <= inflight_pc_reg;
            head_in_reg <= i_imem_rdata;
        end else begin
            head_pc_reg <= pc_mem[head_next];
            head_in_reg <= in_mem[head_next];
        end
    end

    assign o_imem_req   = req;
    assign o_imem_addr  = fetch_pc_reg;
    assign hs_fq4dc_val = val;
    assign o_pc         = head_pc_reg;
    assign o_in         = head_in_reg;
    assign o_count      = rst ? '0 : count_reg;

endmodule

// File: tb/tb_fetch_q.sv
// Bench for fetch_q: directed vector table for the documented scenarios, then a
// randomized run against a queue-based reference model.
module tb_fetch_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        hs_fq4dc_val;
    logic        hs_dc4fq_rdy;
    logic [31:0] o_pc;
    logic [31:0] o_in;
    logic        i_redir;
    logic [31:0] i_redir_pc;
    logic [2:0]  o_count;

    int tests  = 0;
    int failed = 0;

    fetch_q dut (
        .clk          (clk),
        .rst          (rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_rdata (i_imem_rdata),
        .hs_fq4dc_val (hs_fq4dc_val),
        .hs_dc4fq_rdy (hs_dc4fq_rdy),
        .o_pc         (o_pc),
        .o_in         (o_in),
        .i_redir      (i_redir),
        .i_redir_pc   (i_redir_pc),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] redir_pc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_val;
        logic [31:0] exp_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vq[$];

    // Memory side: response for the previous cycle's request, junk otherwise.
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] mem_xor;

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic y,
                       input logic ereq, input logic [31:0] eaddr, input logic eval,
                       input logic [31:0] epc, input logic [2:0] ecnt);
        vec_t v;
        v.rst = r; v.redir = rd; v.redir_pc = rpc; v.rdy = y;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_val = eval; v.exp_pc = epc; v.exp_count = ecnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic end_cycle();
        last_req  = o_imem_req;
        last_addr = o_imem_addr;
        @(posedge clk);
        #1;
        i_imem_rdata = last_req ? (last_addr ^ mem_xor) : $urandom();
    endtask

    // Reference model state
    logic [31:0] pcq[$];
    logic [31:0] inq[$];
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [31:0] m_ipc;

    initial begin
        rst = 1'b1; i_redir = 1'b0; i_redir_pc = '0; hs_dc4fq_rdy = 1'b0;
        i_imem_rdata = '0; mem_xor = '0; last_req = 1'b0; last_addr = '0;

        //  rst redir redir_pc     rdy  req addr          val pc            cnt
        add(1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        0,  1, 32'h80000000, 0, 32'h0,        0);
        add(0, 0, 32'h0,        0,  1, 32'h80000004, 0, 32'h0,        0);
        add(0, 0, 32'h0,        0,  1, 32'h80000008, 1, 32'h80000000, 1);
        add(0, 0, 32'h0,        0,  1, 32'h8000000C, 1, 32'h80000000, 2);
        add(0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h80000000, 3);
        add(0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h80000000, 4);
        add(0, 0, 32'h0,        1,  0, 32'h0,        1, 32'h80000000, 4);
        add(0, 0, 32'h0,        1,  1, 32'h80000010, 1, 32'h80000004, 3);
        add(0, 0, 32'h0,        1,  1, 32'h80000014, 1, 32'h80000008, 2);
        add(0, 0, 32'h0,        1,  1, 32'h80000018, 1, 32'h8000000C, 2);
        add(0, 0, 32'h0,        1,  1, 32'h8000001C, 1, 32'h80000010, 2);
        add(0, 1, 32'h80000103, 1,  0, 32'h0,        0, 32'h0,        2);
        add(0, 0, 32'h0,        1,  1, 32'h80000100, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h80000104, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h80000108, 1, 32'h80000100, 1);
        add(0, 0, 32'h0,        1,  1, 32'h8000010C, 1, 32'h80000104, 1);
        add(0, 1, 32'hFFFFFFFC, 1,  0, 32'h0,        0, 32'h0,        1);
        add(0, 0, 32'h0,        1,  1, 32'hFFFFFFFC, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h00000000, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h00000004, 1, 32'hFFFFFFFC, 1);
        add(0, 0, 32'h0,        1,  1, 32'h00000008, 1, 32'h00000000, 1);
        add(0, 0, 32'h0,        0,  1, 32'h0000000C, 1, 32'h00000004, 1);
        add(0, 0, 32'h0,        0,  1, 32'h00000010, 1, 32'h00000004, 2);
        add(1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h80000000, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h80000004, 0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h80000008, 1, 32'h80000000, 1);
        add(0, 0, 32'h0,        1,  1, 32'h8000000C, 1, 32'h80000004, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; i_redir = vq[i].redir; i_redir_pc = vq[i].redir_pc;
            hs_dc4fq_rdy = vq[i].rdy;
            @(negedge clk);
            $display("[TB] row %0d req=%0b addr=%h val=%0b pc=%h in=%h count=%0d",
                     i, o_imem_req, o_imem_addr, hs_fq4dc_val, o_pc, o_in, o_count);
            chk($sformatf("row%0d_req", i), 32'(o_imem_req), 32'(vq[i].exp_req));
            if (vq[i].exp_req)
                chk($sformatf("row%0d_addr", i), o_imem_addr, vq[i].exp_addr);
            chk($sformatf("row%0d_val", i), 32'(hs_fq4dc_val), 32'(vq[i].exp_val));
            if (vq[i].exp_val) begin
                chk($sformatf("row%0d_pc", i), o_pc, vq[i].exp_pc);
                chk($sformatf("row%0d_in", i), o_in, vq[i].exp_pc);
            end
            chk($sformatf("row%0d_count", i), 32'(o_count), 32'(vq[i].exp_count));
            end_cycle();
        end

        // Randomized phase with a distinct memory pattern so pc and instruction differ.
        mem_xor = 32'hA5A5_5A5A;
        m_fpc = 32'h80000000; m_infl = 1'b0; m_ipc = '0;
        for (int n = 0; n < 3000; n++) begin
            logic exp_req, exp_val;
            logic [2:0] exp_cnt;
            int hi_rdy;
            hi_rdy       = (n / 64) % 2;
            rst          = (n == 0) || ($urandom_range(63) == 0);
            i_redir      = ($urandom_range(15) == 0);
            i_redir_pc   = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15)))
                                                    : $urandom();
            hs_dc4fq_rdy = hi_rdy ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            @(negedge clk);
            exp_req = !rst && !i_redir && ((pcq.size() + int'(m_infl)) < 4);
            exp_val = !rst && !i_redir && (pcq.size() != 0);
            exp_cnt = rst ? 3'd0 : 3'(pcq.size());
            chk("rnd_req", 32'(o_imem_req), 32'(exp_req));
            if (exp_req)
                chk("rnd_addr", o_imem_addr, m_fpc);
            chk("rnd_val", 32'(hs_fq4dc_val), 32'(exp_val));
            if (exp_val) begin
                chk("rnd_pc", o_pc, pcq[0]);
                chk("rnd_in", o_in, inq[0]);
            end
            chk("rnd_count", 32'(o_count), 32'(exp_cnt));
            chk("rnd_count_bound", 32'(o_count <= 3'd4), 32'd1);
            if (rst) begin
                pcq.delete(); inq.delete();
                m_fpc = 32'h80000000; m_infl = 1'b0;
            end else if (i_redir) begin
                pcq.delete(); inq.delete();
                m_fpc = i_redir_pc & ~32'h3; m_infl = 1'b0;
            end else begin
                if (exp_val && hs_dc4fq_rdy) begin
                    $display("[TB] deliver pc=%h in=%h", pcq[0], inq[0]);
                    void'(pcq.pop_front());
                    void'(inq.pop_front());
                end
                if (m_infl) begin
                    pcq.push_back(m_ipc);
                    inq.push_back(i_imem_rdata);
                end
                m_infl = exp_req;
                if (exp_req) begin
                    m_ipc = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
            end
            end_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
